// File: rtl/aes_v1_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES column mixer.
package aes_v1_pkg;

  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned N_BYTES = 4;
  localparam int unsigned COEF_W  = 4;

  // 3-bit FSM state encoding; any other value falls back to idle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4
  } mix_state_e;

  // AES field polynomial x^8+x^4+x^3+x+1 with the x^8 term dropped.
  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

  // Coefficient for a_{i+j} sits in element j.
  typedef logic [N_BYTES-1:0][BYTE_W-1:0] coef_set_t;
  localparam coef_set_t ENC_COEF = {8'd1, 8'd1, 8'd3, 8'd2};
  localparam coef_set_t DEC_COEF = {8'd9, 8'd13, 8'd11, 8'd14};

  // Operand captured at accept time.
  typedef struct packed {
    logic             dec;
    logic [COL_W-1:0] col;
  } mix_op_t;

  // Multiply by x in GF(2^8).
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a small constant (< 16) using a chain of xtime stages.
  function automatic logic [BYTE_W-1:0] gf_mul_coef(input logic [BYTE_W-1:0] x,
                                                    input logic [COEF_W-1:0] c);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] r;
    p = x;
    r = '0;
    for (int k = 0; k < int'(COEF_W); k++) begin
      if (c[k]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_v1_mix_if.sv
// Request/response bus between the SubBytes stage, the mixer and the result bus.
interface aes_v1_mix_if;
  import aes_v1_pkg::*;

  logic             valid;
  logic             dec;
  logic [COL_W-1:0] rs1;
  logic             ready;
  logic [COL_W-1:0] rd;

  modport master (output valid, output dec, output rs1, input ready, input rd);
  modport slave  (input valid, input dec, input rs1, output ready, output rd);
endinterface

// File: rtl/aes_mix_byte.sv
// One output byte of (Inv)MixColumns from a rotated view of the column.
module aes_mix_byte
  import aes_v1_pkg::*;
(
  input  logic [BYTE_W-1:0] a0,
  input  logic [BYTE_W-1:0] a1,
  input  logic [BYTE_W-1:0] a2,
  input  logic [BYTE_W-1:0] a3,
  input  logic              dec,
  output logic [BYTE_W-1:0] b_c
);

  coef_set_t coef_c;

  // Select the coefficient row, then sum the constant products.
  always_comb begin
    coef_c = dec ? DEC_COEF : ENC_COEF;
    b_c    = gf_mul_coef(a0, COEF_W'(coef_c[0]))
           ^ gf_mul_coef(a1, COEF_W'(coef_c[1]))
           ^ gf_mul_coef(a2, COEF_W'(coef_c[2]))
           ^ gf_mul_coef(a3, COEF_W'(coef_c[3]));
  end

endmodule

// File: rtl/aes_v1_mix.sv
// Serial AES (Inv)MixColumns: one output byte per cycle, result after 4 cycles.
module aes_v1_mix
  import aes_v1_pkg::*;
(
  input  logic          g_clk,
  input  logic          g_resetn,
  aes_v1_mix_if.slave   bus
);

  mix_state_e        state_q, state_d;
  mix_op_t           op_q, op_d;
  logic [COL_W-1:0]  rd_q, rd_d;
  logic              ready_q, ready_d;

  mix_op_t           src_c;
  logic [1:0]        sel_c;
  logic [COL_W-1:0]  rot_c;
  logic [BYTE_W-1:0] byte_c;

  // Byte 0 uses the live request; later bytes use the captured operand.
  always_comb begin
    src_c = (state_q == ST_IDLE) ? mix_op_t'{dec: bus.dec, col: bus.rs1} : op_q;
    case (state_q)
      ST_B0:   sel_c = 2'd1;
      ST_B1:   sel_c = 2'd2;
      ST_B2:   sel_c = 2'd3;
      default: sel_c = 2'd0;
    endcase
  end

  // Rotate right by 8*sel so the target byte lands in a0.
  always_comb begin
    case (sel_c)
      2'd1:    rot_c = {src_c.col[7:0],  src_c.col[31:8]};
      2'd2:    rot_c = {src_c.col[15:0], src_c.col[31:16]};
      2'd3:    rot_c = {src_c.col[23:0], src_c.col[31:24]};
      default: rot_c = src_c.col;
    endcase
  end

  aes_mix_byte u_mix_byte (
    .a0  (rot_c[7:0]),
    .a1  (rot_c[15:8]),
    .a2  (rot_c[23:16]),
    .a3  (rot_c[31:24]),
    .dec (src_c.dec),
    .b_c (byte_c)
  );

  // Next state, operand capture and byte loads.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          state_d   = ST_B0;
          op_d      = src_c;
          rd_d[7:0] = byte_c;
        end
      end
      ST_B0: begin
        state_d    = ST_B1;
        rd_d[15:8] = byte_c;
      end
      ST_B1: begin
        state_d     = ST_B2;
        rd_d[23:16] = byte_c;
      end
      ST_B2: begin
        state_d     = ST_B3;
        rd_d[31:24] = byte_c;
        ready_d     = 1'b1;
      end
      ST_B3:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
    end
  end

  // ready_q is set on entry to B3, so it is high exactly while in B3.
  assign bus.ready = ready_q;
  assign bus.rd    = rd_q;

endmodule

// File: doc/aes_v1_mix.md
Name: aes_v1_mix

Overview:
- Size-optimised AES MixColumns (encrypt) / InvMixColumns (decrypt) unit for one 32-bit state column.
- Sits directly downstream of the single-SBox SubBytes unit. It consumes that unit's rd word and produces the mixed column for the core's result bus.
- Instances one GF(2^8) byte-mix datapath and computes one output byte per cycle, finishing in 4 cycles, which matches the upstream unit's cadence.

Parameters:
- none (column width fixed at 32 bits, 4 bytes).

Ports:
- g_clk     input   1   clock; all state updates on rising edge.
- g_resetn  input   1   synchronous, active-low reset.
- valid     input   1   request; input column on rs1 is valid.
- dec       input   1   0 = MixColumns, 1 = InvMixColumns.
- rs1       input   32  input column; byte i = rs1[8i+7:8i] = a_i.
- ready     output  1   single-cycle pulse; rd holds the finished result.
- rd        output  32  output column; byte i = b_i.

Behaviour:
- Interface rule: one clock, g_clk. Reset g_resetn is synchronous and active-low, sampled on the g_clk rising edge.
- Reset values: fsm = IDLE, ready = 0, rd = 32'h0, latched operand = 0, latched dec = 0.
- FSM states: IDLE, B0, B1, B2, B3.
  - IDLE -> B0 when valid, else stay in IDLE.
  - B0 -> B1 -> B2 -> B3 unconditionally.
  - B3 -> IDLE.
  - Unused encodings -> IDLE.
- Accept (cycle 0): fsm == IDLE && valid.
  - rs1 and dec are latched into internal registers.
  - Output byte 0 is computed from live rs1/dec and loaded into rd[7:0].
  - After accept, rs1, dec and valid may change freely.
- Later output bytes, all computed from the latched operand and latched dec:
  - B0 loads rd[15:8] (byte 1).
  - B1 loads rd[23:16] (byte 2).
  - B2 loads rd[31:24] (byte 3).
- ready = (fsm == B3), combinational from state. It is high exactly one cycle, 4 cycles after the accept cycle.
- rd is only meaningful while ready = 1. It holds its value after ready until the next accept overwrites byte 0.
- Byte function, indices mod 4:
  - Encrypt: b_i = 2*a_i ^ 3*a_{i+1} ^ a_{i+2} ^ a_{i+3}.
  - Decrypt: b_i = 14*a_i ^ 11*a_{i+1} ^ 13*a_{i+2} ^ 9*a_{i+3}.
  - Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (reduction constant 8'h1B).
  - One shared datapath evaluates this on a byte-rotated view of the operand: rotate right by 8*i bits for byte i.
- valid while fsm != IDLE, including during B3: ignored, no queuing.
- Back-to-back: the earliest next accept is the cycle after ready. The throughput is therefore one column per 5 cycles.
- Reset asserted mid-operation: the operation is aborted. The next cycle shows IDLE, ready = 0, rd = 0, and no ready pulse is produced for the aborted request.
- Both dec values use the same latency.

Decomposition:
- Shared package aes_v1_pkg holds:
  - FSM state encodings (3-bit IDLE..B3).
  - AES reduction polynomial constant 8'h1B.
  - Encrypt coefficient set {2,3,1,1} and decrypt coefficient set {14,11,13,9}.
- One combinational sub-module, aes_mix_byte.
  - Inputs: four bytes a0..a3 and dec.
  - Output: one mixed byte.
  - Built from xtime stages; the decrypt multiples are formed from chained xtime values.
- Top level holds the FSM, the operand/dec latch, the rotation mux and the byte registers.

Test Plan:
- Encrypt vector: rs1 = 32'h455313DB, dec = 0, valid for 1 cycle -> ready high exactly on cycle 4 with rd = 32'hBCA14D8E, ready low on cycles 1-3 and cycle 5.
- Decrypt vector and operand latching: rs1 = 32'hBCA14D8E, dec = 1, accepted, then rs1 driven to 32'hFFFFFFFF and dec to 0 from cycle 1 -> rd = 32'h455313DB at ready.
- Encrypt vectors, back-to-back:
  - rs1 = 32'h5C220AF2 -> 32'h9D58DC9F.
  - Then rs1 = 32'hD5D4D4D4 -> 32'hD6D7D5D5, with valid held high continuously.
  - Second accept occurs the cycle after the first ready; valid during B0-B3 is ignored (exactly 2 ready pulses in 10 cycles).
- Fixed points: rs1 = 32'h01010101 and rs1 = 32'hC6C6C6C6, each with dec = 0 and dec = 1 -> rd equals rs1 in all four cases.
- Reset mid-op: accept 32'h455313DB, assert g_resetn = 0 in B1 for 1 cycle -> next cycle fsm = IDLE, ready = 0, rd = 0, no ready pulse afterwards. A fresh request then completes correctly.
- Reset values: hold g_resetn = 0 for 3 cycles with valid = 1 -> ready = 0, rd = 0, no accept. Release reset -> accept occurs on the first cycle with g_resetn = 1.
